// File: rtl/expmod_pkg.sv
// Shared definitions for the modular-exponentiation front end.
//   state_e        : command-parser frame state
//   SYNC_BYTE_DEF  : default frame start marker
//   DEF_*          : default operand widths and their field byte counts
//   field_bytes()  : byte count of a field of the given bit width
package expmod_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_VALUE    = 3'd1,
      ST_MODULUS  = 3'd2,
      ST_EXPONENT = 3'd3,
      ST_CHECK    = 3'd4,
      ST_ISSUE    = 3'd5
   } state_e;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   localparam int DEF_MSG_WIDTH = 16;
   localparam int DEF_KEY_WIDTH = 32;
   localparam int DEF_MSG_BYTES = DEF_MSG_WIDTH / 8;
   localparam int DEF_KEY_BYTES = DEF_KEY_WIDTH / 8;

   function automatic int field_bytes(input int width);
      return width / 8;
   endfunction

endpackage

// File: rtl/expmod_cmd_parser.sv
// Byte-stream command parser for the expmod core.
// Assembles frames (sync, value, modulus, exponent, XOR checksum; MSB byte
// first), publishes the operands on a checksum match and pulses ready_out once
// the core is not busy. Bad, timed-out or overrun frames are counted.
// Ports:
//   clk_in, rst_in (sync, active-low)
//   byte_valid_in/byte_in : incoming byte strobe and data
//   expmod_busy_in        : core busy, holds off the start pulse
//   value_out/modulus_out/exponent_out : operands, change only on a good frame
//   ready_out             : one-cycle start pulse
//   frame_err_out         : one-cycle pulse per dropped frame
//   err_count_out         : saturating dropped-frame count
module expmod_cmd_parser
   import expmod_pkg::*;
#(
   parameter int         MSG_WIDTH      = DEF_MSG_WIDTH,
   parameter int         KEY_WIDTH      = DEF_KEY_WIDTH,
   parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
   parameter int         TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 byte_valid_in,
   input  logic [7:0]           byte_in,
   input  logic                 expmod_busy_in,
   output logic [MSG_WIDTH-1:0] value_out,
   output logic [KEY_WIDTH-1:0] modulus_out,
   output logic [KEY_WIDTH-1:0] exponent_out,
   output logic                 ready_out,
   output logic                 frame_err_out,
   output logic [7:0]           err_count_out
);

   localparam int MSG_BYTES = field_bytes(MSG_WIDTH);
   localparam int KEY_BYTES = field_bytes(KEY_WIDTH);
   localparam int MAX_BYTES = (MSG_BYTES > KEY_BYTES) ? MSG_BYTES : KEY_BYTES;
   localparam int CNT_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
   localparam int GAP_W     = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MSG_BYTES - 1);
   localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_BYTES - 1);
   // Firing on the last count value makes the error land exactly
   // TIMEOUT_CYCLES edges after the most recent byte.
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

   if ((MSG_WIDTH % 8) != 0 || MSG_WIDTH < 8) begin : g_bad_msg_width
      $error("expmod_cmd_parser: MSG_WIDTH must be a non-zero multiple of 8");
   end
   if ((KEY_WIDTH % 8) != 0 || KEY_WIDTH < 8) begin : g_bad_key_width
      $error("expmod_cmd_parser: KEY_WIDTH must be a non-zero multiple of 8");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("expmod_cmd_parser: TIMEOUT_CYCLES must be at least 1");
   end

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [GAP_W-1:0]     gap_q, gap_d;
   logic [7:0]           csum_q, csum_d;
   logic [MSG_WIDTH-1:0] val_sh_q, val_sh_d;
   logic [KEY_WIDTH-1:0] mod_sh_q, mod_sh_d;
   logic [KEY_WIDTH-1:0] exp_sh_q, exp_sh_d;
   logic [MSG_WIDTH-1:0] value_q, value_d;
   logic [KEY_WIDTH-1:0] modulus_q, modulus_d;
   logic [KEY_WIDTH-1:0] exponent_q, exponent_d;
   logic                 ready_q, ready_d;
   logic                 frame_err_q, frame_err_d;
   logic [7:0]           err_cnt_q, err_cnt_d;
   logic                 drop;
   logic                 in_frame;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      gap_d      = gap_q;
      csum_d     = csum_q;
      val_sh_d   = val_sh_q;
      mod_sh_d   = mod_sh_q;
      exp_sh_d   = exp_sh_q;
      value_d    = value_q;
      modulus_d  = modulus_q;
      exponent_d = exponent_q;
      ready_d    = 1'b0;
      drop       = 1'b0;
      in_frame   = (state_q == ST_VALUE) || (state_q == ST_MODULUS) ||
                   (state_q == ST_EXPONENT) || (state_q == ST_CHECK);

      case (state_q)
         ST_IDLE: begin
            if (byte_valid_in && (byte_in == SYNC_BYTE)) begin
               state_d = ST_VALUE;
               cnt_d   = '0;
               csum_d  = '0;
            end
         end
         ST_VALUE: begin
            if (byte_valid_in) begin
               val_sh_d = (val_sh_q << 8) | MSG_WIDTH'(byte_in);
               csum_d   = csum_q ^ byte_in;
               cnt_d    = (cnt_q == MSG_LAST) ? '0 : cnt_q + CNT_W'(1);
               if (cnt_q == MSG_LAST) state_d = ST_MODULUS;
            end
         end
         ST_MODULUS: begin
            if (byte_valid_in) begin
               mod_sh_d = (mod_sh_q << 8) | KEY_WIDTH'(byte_in);
               csum_d   = csum_q ^ byte_in;
               cnt_d    = (cnt_q == KEY_LAST) ? '0 : cnt_q + CNT_W'(1);
               if (cnt_q == KEY_LAST) state_d = ST_EXPONENT;
            end
         end
         ST_EXPONENT: begin
            if (byte_valid_in) begin
               exp_sh_d = (exp_sh_q << 8) | KEY_WIDTH'(byte_in);
               csum_d   = csum_q ^ byte_in;
               cnt_d    = (cnt_q == KEY_LAST) ? '0 : cnt_q + CNT_W'(1);
               if (cnt_q == KEY_LAST) state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (byte_valid_in) begin
               if (byte_in == csum_q) begin
                  value_d    = val_sh_q;
                  modulus_d  = mod_sh_q;
                  exponent_d = exp_sh_q;
                  state_d    = ST_ISSUE;
               end else begin
                  drop    = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_ISSUE: begin
            // An overrun byte is reported but the pending start survives.
            if (byte_valid_in) drop = 1'b1;
            if (!expmod_busy_in) begin
               ready_d = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Gap counter: a byte always clears it, so a byte on the timeout edge wins.
      if (!in_frame || byte_valid_in) begin
         gap_d = '0;
      end else if (gap_q == GAP_LAST) begin
         gap_d   = '0;
         drop    = 1'b1;
         state_d = ST_IDLE;
      end else begin
         gap_d = gap_q + GAP_W'(1);
      end

      frame_err_d = drop;
      err_cnt_d   = (drop && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         gap_q       <= '0;
         csum_q      <= '0;
         val_sh_q    <= '0;
         mod_sh_q    <= '0;
         exp_sh_q    <= '0;
         value_q     <= '0;
         modulus_q   <= '0;
         exponent_q  <= '0;
         ready_q     <= 1'b0;
         frame_err_q <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         gap_q       <= gap_d;
         csum_q      <= csum_d;
         val_sh_q    <= val_sh_d;
         mod_sh_q    <= mod_sh_d;
         exp_sh_q    <= exp_sh_d;
         value_q     <= value_d;
         modulus_q   <= modulus_d;
         exponent_q  <= exponent_d;
         ready_q     <= ready_d;
         frame_err_q <= frame_err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign value_out     = value_q;
   assign modulus_out   = modulus_q;
   assign exponent_out  = exponent_q;
   assign ready_out     = ready_q;
   assign frame_err_out = frame_err_q;
   assign err_count_out = err_cnt_q;

endmodule

// File: tb/tb_expmod_cmd_parser.sv
// Testbench for expmod_cmd_parser: table of frames plus hand-written
// sequences for latency, busy hold-off/overrun, junk, timeout, reset and
// error-count saturation. Expected operands go into a scoreboard queue when a
// good frame is sent and are compared when ready_out fires.
module tb_expmod_cmd_parser;

   localparam int MW = 16;
   localparam int KW = 32;
   localparam int TO = 100;

   logic          clk_in = 1'b0;
   logic          rst_in = 1'b0;
   logic          byte_valid_in = 1'b0;
   logic [7:0]    byte_in = 8'h00;
   logic          expmod_busy_in = 1'b0;
   logic [MW-1:0] value_out;
   logic [KW-1:0] modulus_out;
   logic [KW-1:0] exponent_out;
   logic          ready_out;
   logic          frame_err_out;
   logic [7:0]    err_count_out;

   always #5 clk_in = ~clk_in;

   expmod_cmd_parser #(
      .MSG_WIDTH(MW), .KEY_WIDTH(KW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in), .byte_valid_in(byte_valid_in),
      .byte_in(byte_in), .expmod_busy_in(expmod_busy_in),
      .value_out(value_out), .modulus_out(modulus_out), .exponent_out(exponent_out),
      .ready_out(ready_out), .frame_err_out(frame_err_out), .err_count_out(err_count_out)
   );

   typedef struct {
      logic [MW-1:0] v;
      logic [KW-1:0] m;
      logic [KW-1:0] e;
   } op_t;

   typedef struct {
      op_t o;
      bit  bad;
   } vec_t;

   int   errors = 0;
   int   checks = 0;
   int   ready_seen = 0;
   int   err_seen = 0;
   op_t  sb_q[$];
   op_t  last;
   int   exp_cnt;
   int   e0, r0;
   vec_t vecs[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Output monitor: counts pulses and pops the scoreboard on each start pulse.
   initial begin : monitor
      logic b;
      op_t  x;
      forever begin
         @(posedge clk_in);
         b = expmod_busy_in;
         #1;
         if (frame_err_out) err_seen++;
         if (ready_out) begin
            ready_seen++;
            check("ready_while_busy", b, 1'b0);
            check("sb_nonempty", sb_q.size() != 0, 1'b1);
            if (sb_q.size() != 0) begin
               x = sb_q.pop_front();
               check("sb_value", value_out, x.v);
               check("sb_modulus", modulus_out, x.m);
               check("sb_exponent", exponent_out, x.e);
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk_in);
      byte_valid_in = 1'b1;
      byte_in = b;
   endtask

   task automatic end_bytes();
      @(negedge clk_in);
      byte_valid_in = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   // Sends a full frame; idle_after_sync > 0 inserts end_bytes + that many idle
   // cycles between the sync byte and the first payload byte.
   task automatic send_frame(input op_t o, input bit bad, input bit push,
                             input int idle_after_sync);
      logic [7:0] f[12];
      logic [7:0] cs;
      f[0] = 8'hA5;
      for (int i = 0; i < 2; i++) f[1 + i] = o.v[15 - 8*i -: 8];
      for (int i = 0; i < 4; i++) f[3 + i] = o.m[31 - 8*i -: 8];
      for (int i = 0; i < 4; i++) f[7 + i] = o.e[31 - 8*i -: 8];
      cs = 8'h00;
      for (int i = 1; i < 11; i++) cs = cs ^ f[i];
      f[11] = bad ? (cs ^ 8'h01) : cs;
      if (push) sb_q.push_back(o);
      for (int i = 0; i < 12; i++) begin
         send_byte(f[i]);
         if (i == 0 && idle_after_sync > 0) begin
            end_bytes();
            idle(idle_after_sync);
         end
      end
      end_bytes();
   endtask

   initial begin : test
      vecs[0] = '{o: '{v: 16'h0007, m: 32'h0000_0431, e: 32'h0000_0048}, bad: 1'b1};
      vecs[1] = '{o: '{v: 16'hFFFF, m: 32'hFFFF_FFFF, e: 32'hFFFF_FFFF}, bad: 1'b0};
      vecs[2] = '{o: '{v: 16'hA5A5, m: 32'h0000_00A5, e: 32'hA500_0000}, bad: 1'b0};
      vecs[3] = '{o: '{v: 16'h1234, m: 32'h5678_9ABC, e: 32'hDEF0_1357}, bad: 1'b1};
      vecs[4] = '{o: '{v: 16'h8001, m: 32'h8000_0001, e: 32'h0000_0003}, bad: 1'b0};
      vecs[5] = '{o: '{v: 16'h0000, m: 32'h0000_0000, e: 32'h0000_0000}, bad: 1'b0};

      // Reset state
      rst_in = 1'b0;
      idle(3);
      check("rst_value", value_out, 0);
      check("rst_modulus", modulus_out, 0);
      check("rst_exponent", exponent_out, 0);
      check("rst_ready", ready_out, 0);
      check("rst_frame_err", frame_err_out, 0);
      check("rst_err_count", err_count_out, 0);
      rst_in = 1'b1;
      idle(2);
      exp_cnt = 0;

      // Reference frame A5 00 07 00 00 04 31 00 00 00 48 7A, latency check
      sb_q.push_back('{v: 16'h0007, m: 32'h0000_0431, e: 32'h0000_0048});
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h07);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h04); send_byte(8'h31);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h48);
      send_byte(8'h7A);
      @(posedge clk_in); #1;
      check("lat_ready_n", ready_out, 0);
      check("lat_value", value_out, 16'h0007);
      check("lat_modulus", modulus_out, 32'h0000_0431);
      check("lat_exponent", exponent_out, 32'h0000_0048);
      @(negedge clk_in);
      byte_valid_in = 1'b0;
      @(posedge clk_in); #1;
      check("lat_ready_n1", ready_out, 1);
      @(posedge clk_in); #1;
      check("lat_ready_n2", ready_out, 0);
      check("lat_no_err", err_count_out, 0);
      last = '{v: 16'h0007, m: 32'h0000_0431, e: 32'h0000_0048};
      idle(3);

      // Table of frames
      for (int k = 0; k < 6; k++) begin
         e0 = err_seen;
         r0 = ready_seen;
         send_frame(vecs[k].o, vecs[k].bad, !vecs[k].bad, 0);
         idle(4);
         if (vecs[k].bad) exp_cnt++;
         else last = vecs[k].o;
         check($sformatf("vec%0d_err_count", k), err_count_out, exp_cnt);
         check($sformatf("vec%0d_err_pulses", k), err_seen - e0, vecs[k].bad ? 1 : 0);
         check($sformatf("vec%0d_ready_pulses", k), ready_seen - r0, vecs[k].bad ? 0 : 1);
         check($sformatf("vec%0d_value", k), value_out, last.v);
         check($sformatf("vec%0d_modulus", k), modulus_out, last.m);
         check($sformatf("vec%0d_exponent", k), exponent_out, last.e);
      end

      // Busy hold-off with an overrun byte during the wait
      expmod_busy_in = 1'b1;
      r0 = ready_seen;
      last = '{v: 16'h0BAD, m: 32'h1234_5678, e: 32'h9ABC_DEF0};
      send_frame(last, 1'b0, 1'b1, 0);
      idle(3);
      send_byte(8'h11);
      end_bytes();
      idle(44);
      exp_cnt++;
      check("busy_err_count", err_count_out, exp_cnt);
      check("busy_ready_held", ready_seen - r0, 0);
      check("busy_value", value_out, last.v);
      check("busy_modulus", modulus_out, last.m);
      check("busy_exponent", exponent_out, last.e);
      @(negedge clk_in);
      expmod_busy_in = 1'b0;
      @(posedge clk_in); #1;
      check("busy_release_ready", ready_out, 1);
      @(posedge clk_in); #1;
      check("busy_release_ready_off", ready_out, 0);
      check("busy_ready_pulses", ready_seen - r0, 1);
      idle(2);

      // Junk bytes before a good frame
      e0 = err_seen;
      r0 = ready_seen;
      send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
      last = '{v: 16'h4242, m: 32'h0101_0101, e: 32'h0000_FFFF};
      send_frame(last, 1'b0, 1'b1, 0);
      idle(4);
      check("junk_err_pulses", err_seen - e0, 0);
      check("junk_err_count", err_count_out, exp_cnt);
      check("junk_ready_pulses", ready_seen - r0, 1);

      // Timeout after A5 00
      send_byte(8'hA5);
      send_byte(8'h00);
      @(negedge clk_in);
      byte_valid_in = 1'b0;
      for (int k = 1; k <= TO; k++) begin
         @(posedge clk_in); #1;
         if (k == TO - 1) check("timeout_early", frame_err_out, 0);
         if (k == TO) check("timeout_pulse", frame_err_out, 1);
      end
      exp_cnt++;
      check("timeout_err_count", err_count_out, exp_cnt);
      idle(2);
      r0 = ready_seen;
      last = '{v: 16'h00C3, m: 32'h0000_1001, e: 32'h0000_0011};
      send_frame(last, 1'b0, 1'b1, 0);
      idle(4);
      check("post_timeout_ready", ready_seen - r0, 1);

      // Byte landing on the timeout edge wins
      e0 = err_seen;
      r0 = ready_seen;
      last = '{v: 16'h7E7E, m: 32'h0F0F_0F0F, e: 32'h0000_0101};
      send_frame(last, 1'b0, 1'b1, TO - 2);
      idle(4);
      check("edge_byte_no_err", err_seen - e0, 0);
      check("edge_byte_ready", ready_seen - r0, 1);

      // Reset mid-frame
      send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34);
      send_byte(8'h56); send_byte(8'h78);
      @(negedge clk_in);
      byte_valid_in = 1'b0;
      rst_in = 1'b0;
      @(negedge clk_in);
      rst_in = 1'b1;
      check("midrst_value", value_out, 0);
      check("midrst_modulus", modulus_out, 0);
      check("midrst_exponent", exponent_out, 0);
      check("midrst_ready", ready_out, 0);
      check("midrst_frame_err", frame_err_out, 0);
      check("midrst_err_count", err_count_out, 0);
      exp_cnt = 0;
      idle(2);
      r0 = ready_seen;
      last = '{v: 16'h3C3C, m: 32'hCAFE_F00D, e: 32'h0001_0001};
      send_frame(last, 1'b0, 1'b1, 0);
      idle(4);
      check("post_rst_ready", ready_seen - r0, 1);
      check("post_rst_value", value_out, last.v);

      // Saturation of the dropped-frame counter
      e0 = err_seen;
      for (int k = 0; k < 300; k++)
         send_frame('{v: 16'h0001, m: 32'h0000_0002, e: 32'h0000_0003}, 1'b1, 1'b0, 0);
      idle(4);
      check("sat_err_count", err_count_out, 8'hFF);
      check("sat_err_pulses", err_seen - e0, 300);
      check("sat_value_kept", value_out, last.v);

      check("sb_drained", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/expmod_cmd_parser.md
# expmod_cmd_parser

Upstream front end for the modular-exponentiation engine. Consumes the byte stream from the UART receiver and assembles framed requests (sync, value, modulus, exponent, XOR checksum). On each checksum-verified frame it presents stable operands and issues a one-cycle start pulse to the expmod core, holding off while the core is busy. Malformed, timed-out or overrun frames are dropped and counted.

## Interface
Parameters:
- MSG_WIDTH, 16: value operand width in bits; must be a multiple of 8.
- KEY_WIDTH, 32: modulus and exponent width in bits; must be a multiple of 8.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CYCLES, 1_000_000: maximum gap between bytes inside a frame (10 ms at 100 MHz).

Ports:
- clk_in  input  1  system clock (100 MHz).
- rst_in  input  1  reset. Synchronous and active-low; one clock domain.
- byte_valid_in  input  1  one-cycle strobe; byte_in is valid.
- byte_in  input  8  received byte.
- expmod_busy_in  input  1  downstream core busy.
- value_out  output  MSG_WIDTH  value operand.
- modulus_out  output  KEY_WIDTH  modulus operand.
- exponent_out  output  KEY_WIDTH  exponent operand.
- ready_out  output  1  one-cycle start pulse to the core.
- frame_err_out  output  1  one-cycle pulse per dropped frame.
- err_count_out  output  8  saturating count of dropped frames.

## Operation
- Frame format: SYNC_BYTE, value (MSG_WIDTH/8 bytes), modulus (KEY_WIDTH/8 bytes), exponent (KEY_WIDTH/8 bytes), checksum. All fields are MSB byte first. The checksum is the XOR of all payload bytes and excludes sync.
- States:
  - IDLE: a byte equal to SYNC_BYTE moves to VALUE. Any other byte is discarded silently.
  - VALUE, MODULUS, EXPONENT: each byte shifts into a shadow register and XORs into the running checksum. A byte counter advances the state when each field fills.
  - CHECK: the next byte is compared with the checksum.
    - On match: copy shadows into the operand output registers and go to ISSUE.
    - On mismatch: pulse frame_err_out, increment err_count_out, go to IDLE.
  - ISSUE: when expmod_busy_in is sampled low, assert ready_out for one cycle and go to IDLE. Stay in ISSUE while busy.
- Timeout:
  - In VALUE, MODULUS, EXPONENT and CHECK, a gap counter clears on every byte.
  - When the counter reaches TIMEOUT_CYCLES: pulse frame_err_out, increment err_count_out, go to IDLE.
  - The counter is idle in IDLE and ISSUE.
- Overrun: a byte arriving in ISSUE is dropped, pulses frame_err_out and increments err_count_out. The ISSUE state is kept and the pending request is not lost.
- err_count_out saturates at 255 and never wraps.
- Operand outputs change only on checksum pass and stay stable until the next accepted frame.

## Timing
- Reset: all outputs are 0. State is IDLE; shadows, checksum and counters are cleared.
- Reset mid-frame discards the partial frame and zeroes the operand outputs.
- Checksum byte accepted at edge N:
  - Operand outputs are valid from cycle N+1.
  - With busy low, ready_out is high during cycle N+2, exactly one cycle.
- If busy is high, ready_out is high the cycle after busy is first sampled low in ISSUE.
- Timeout and byte in the same cycle: the byte wins and the counter clears.
- frame_err_out is registered and rises the cycle after the error condition. err_count_out updates on the same edge.
- ready_out is never asserted while expmod_busy_in was high on the sampling edge.
- Byte throughput: one byte per cycle is accepted with no back-pressure.

## Structure
- Shared package expmod_pkg holds:
  - the state enum.
  - the SYNC_BYTE default.
  - field byte-count constants: MSG_BYTES = MSG_WIDTH/8, KEY_BYTES = KEY_WIDTH/8.
- Add elaboration-time checks that MSG_WIDTH and KEY_WIDTH are multiples of 8.
- Single module, no sub-module; the gap counter and byte counter are inline.

## Test plan
- Good frame A5 00 07 00 00 04 31 00 00 00 48 7A with busy low:
  - value 0x0007, modulus 0x00000431, exponent 0x00000048.
  - ready_out high exactly one cycle, two cycles after the 7A strobe.
  - No frame_err_out.
- Same frame with checksum 7B:
  - No ready_out; frame_err_out one pulse; err_count_out=1.
  - Operand outputs keep their previous values.
- Good frame with busy high for 50 cycles, plus byte 0x11 sent during the wait:
  - ready_out is held off and fires the cycle after busy is sampled low.
  - err_count_out increments once; the operands are intact.
- Junk 00 FF 5A, then a good frame: the junk causes no error and the frame is accepted normally.
- TIMEOUT_CYCLES=100, send A5 00 then stop:
  - frame_err_out pulses 100 cycles after the last byte.
  - A following good frame is accepted.
- rst_in low for 1 cycle after 5 bytes of a frame:
  - All outputs read 0.
  - A following good frame is accepted.
  - 300 bad frames leave err_count_out saturated at 255.
